// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the register-file
// clear-sequencer state encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } rf_state_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file. The core
// side uses the master modport; the register file uses the slave modport.
interface reg_file_sb_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] R_Addr_A;
  logic [DATA_W-1:0] R_Data_A;
  logic              R_Busy_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic [DATA_W-1:0] R_Data_B;
  logic              R_Busy_B;
  logic              Write_Reg;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Issue_Valid;
  logic [ADDR_W-1:0] Issue_Addr;
  logic              Clear_Req;
  logic              Clear_Busy;

  modport master (
    output R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data,
           Issue_Valid, Issue_Addr, Clear_Req,
    input  R_Data_A, R_Busy_A, R_Data_B, R_Busy_B, Clear_Busy
  );

  modport slave (
    input  R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data,
           Issue_Valid, Issue_Addr, Clear_Req,
    output R_Data_A, R_Busy_A, R_Data_B, R_Busy_B, Clear_Busy
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: looks up the stored entry and busy bit,
// forwards a same-cycle write (bypass) and applies the hardwired-zero rule.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              idle,
  input  logic              write_reg,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] entries [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy,
  output logic [DATA_W-1:0] data,
  output logic              busy_out
);

  logic is_zero;
  logic bypass_hit;

  // Zero register wins over bypass, and a write in flight both supplies the
  // data and retires the pending producer as far as this reader is concerned.
  always_comb begin
    is_zero    = (ZERO_REG != 0) && (addr == '0);
    bypass_hit = idle && write_reg && (w_addr == addr);
    data       = entries[addr];
    busy_out   = busy[addr];
    if (is_zero) begin
      data     = '0;
      busy_out = 1'b0;
    end else if (bypass_hit) begin
      data     = w_data;
      busy_out = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with write bypass, optional hardwired zero
// register, per-entry busy scoreboard and a one-entry-per-cycle clear sweep.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  reg_file_sb_if.slave bus
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  logic [DATA_W-1:0] entries [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic idle;
  logic write_en;
  logic issue_en;

  assign idle     = (state == IDLE);
  assign write_en = idle && bus.Write_Reg &&
                    !((ZERO_REG != 0) && (bus.W_Addr == '0));
  assign issue_en = idle && bus.Issue_Valid &&
                    !((ZERO_REG != 0) && (bus.Issue_Addr == '0));

  assign bus.Clear_Busy = (state == SWEEP);

  // Clear sequencer state and sweep pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Accept a clear only when idle; a sweep visits every entry once and returns.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.Clear_Req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Register storage: normal writes when idle, one entry zeroed per sweep cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (state == SWEEP) begin
      entries[cnt] <= '0;
    end else if (write_en) begin
      entries[bus.W_Addr] <= bus.W_Data;
    end
  end

  // Scoreboard: a write retires the producer, a new issue (even to the same
  // entry in the same cycle) marks it pending again; the sweep clears as it goes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy <= '0;
    end else if (state == SWEEP) begin
      busy[cnt] <= 1'b0;
    end else begin
      if (write_en) begin
        busy[bus.W_Addr] <= 1'b0;
      end
      if (issue_en) begin
        busy[bus.Issue_Addr] <= 1'b1;
      end
    end
  end

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .addr     (bus.R_Addr_A),
    .idle     (idle),
    .write_reg(bus.Write_Reg),
    .w_addr   (bus.W_Addr),
    .w_data   (bus.W_Data),
    .entries  (entries),
    .busy     (busy),
    .data     (bus.R_Data_A),
    .busy_out (bus.R_Busy_A)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .addr     (bus.R_Addr_B),
    .idle     (idle),
    .write_reg(bus.Write_Reg),
    .w_addr   (bus.W_Addr),
    .w_data   (bus.W_Data),
    .entries  (entries),
    .busy     (busy),
    .data     (bus.R_Data_B),
    .busy_out (bus.R_Busy_B)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1):
// directed vector table, hand-written clear/reset sequences and random traffic
// compared against a simple array-based model.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents, pending producers, and how much sweep is left.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  int            m_sweep_left;
  int            m_sweep_idx;

  typedef struct {
    bit            wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            iss;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    bit            ba;
    bit            bb;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (m_sweep_left == 0 && bus.Write_Reg && bus.W_Addr == a) return bus.W_Data;
    return m_mem[a];
  endfunction

  function automatic bit model_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_sweep_left == 0 && bus.Write_Reg && bus.W_Addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_sweep_left = 0;
    m_sweep_idx  = 0;
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  task automatic model_edge();
    if (m_sweep_left > 0) begin
      m_mem[m_sweep_idx]  = '0;
      m_busy[m_sweep_idx] = 1'b0;
      m_sweep_idx++;
      m_sweep_left--;
      if (m_sweep_left == 0) m_sweep_idx = 0;
    end else begin
      if (bus.Write_Reg && bus.W_Addr != 0) begin
        m_mem[bus.W_Addr]  = bus.W_Data;
        m_busy[bus.W_Addr] = 1'b0;
      end
      if (bus.Issue_Valid && bus.Issue_Addr != 0) m_busy[bus.Issue_Addr] = 1'b1;
      if (bus.Clear_Req) begin
        m_sweep_left = DEPTH;
        m_sweep_idx  = 0;
      end
    end
  endtask

  task automatic check_output();
    check("data_a", bus.R_Data_A, model_data(bus.R_Addr_A));
    check("data_b", bus.R_Data_B, model_data(bus.R_Addr_B));
    check("busy_a", DW'(bus.R_Busy_A), DW'(model_busy(bus.R_Addr_A)));
    check("busy_b", DW'(bus.R_Busy_B), DW'(model_busy(bus.R_Addr_B)));
    check("clear_busy", DW'(bus.Clear_Busy), DW'(m_sweep_left > 0));
  endtask

  // One cycle: check combinational outputs at negedge, then clock the model.
  task automatic step();
    @(negedge Clk);
    check_output();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic apply_stimulus(input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input bit iss, input logic [AW-1:0] ia, input bit clr,
                                input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    bus.Write_Reg   = wr;
    bus.W_Addr      = wa;
    bus.W_Data      = wd;
    bus.Issue_Valid = iss;
    bus.Issue_Addr  = ia;
    bus.Clear_Req   = clr;
    bus.R_Addr_A    = ra;
    bus.R_Addr_B    = rb;
  endtask

  task automatic idle_inputs();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    int busy_cycles;

    //               wr  wa   wd            iss ia  ra  rb  ea            eb            ba bb
    vecs[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2]  = '{1, 5'd7, 32'h12345678, 0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h12345678, 0, 0};
    vecs[3]  = '{1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd7, 32'h0,        32'h12345678, 0, 0};
    vecs[4]  = '{0, 5'd0, 32'h0,        1, 5'd9, 5'd0, 5'd9, 32'h0,        32'h0,        0, 0};
    vecs[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        1, 0};
    vecs[6]  = '{1, 5'd9, 32'h000000AA, 0, 5'd0, 5'd9, 5'd5, 32'h000000AA, 32'hDEADBEEF, 0, 0};
    vecs[7]  = '{1, 5'd9, 32'h000000BB, 1, 5'd9, 5'd9, 5'd9, 32'h000000BB, 32'h000000BB, 0, 0};
    vecs[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd0, 32'h000000BB, 32'h0,        1, 0};
    vecs[9]  = '{1, 5'd3, 32'h00000055, 0, 5'd0, 5'd3, 5'd9, 32'h00000055, 32'h000000BB, 0, 1};
    vecs[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd7, 32'h00000055, 32'h12345678, 0, 0};

    // Reset state
    idle_inputs();
    Reset = 1'b1;
    model_reset();
    #12;
    bus.R_Addr_A = 5'd17;
    bus.R_Addr_B = 5'd31;
    #1;
    check("rst_data_a", bus.R_Data_A, 32'h0);
    check("rst_data_b", bus.R_Data_B, 32'h0);
    check("rst_busy_a", DW'(bus.R_Busy_A), 32'h0);
    check("rst_clear_busy", DW'(bus.Clear_Busy), 32'h0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].iss, vecs[i].ia,
                     1'b0, vecs[i].ra, vecs[i].rb);
      @(negedge Clk);
      check($sformatf("vec%0d_data_a", i), bus.R_Data_A, vecs[i].ea);
      check($sformatf("vec%0d_data_b", i), bus.R_Data_B, vecs[i].eb);
      check($sformatf("vec%0d_busy_a", i), DW'(bus.R_Busy_A), DW'(vecs[i].ba));
      check($sformatf("vec%0d_busy_b", i), DW'(bus.R_Busy_B), DW'(vecs[i].bb));
      check_output();
      @(posedge Clk);
      model_edge();
      #1;
    end

    // Fill 1..31, then a one-cycle clear pulse with a dropped write mid-sweep
    for (int a = 1; a < DEPTH; a++) begin
      apply_stimulus(1'b1, AW'(a), 32'h1000 + a, 1'b0, '0, 1'b0, AW'(a), '0);
      step();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd3, 5'd20);
    step();
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(k == 10, 5'd3, 32'h00000BAD, k == 12, 5'd4, 1'b0, 5'd3, AW'(k));
      @(negedge Clk);
      if (bus.Clear_Busy) busy_cycles++;
      check_output();
      @(posedge Clk);
      model_edge();
      #1;
    end
    check("sweep_len", DW'(busy_cycles), 32'd32);
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      bus.R_Addr_A = AW'(a);
      bus.R_Addr_B = AW'(a);
      #1;
      check($sformatf("swept_%0d", a), bus.R_Data_A, 32'h0);
      check($sformatf("swept_busy_%0d", a), DW'(bus.R_Busy_B), 32'h0);
    end

    // Reset at sweep cycle 10 aborts immediately
    for (int a = 20; a < 26; a++) begin
      apply_stimulus(1'b1, AW'(a), 32'hC0DE0000 + a, 1'b1, AW'(a - 10), 1'b0, AW'(a), '0);
      step();
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd20, 5'd15);
    step();
    bus.Clear_Req = 1'b0;
    for (int k = 0; k < 10; k++) step();
    Reset = 1'b1;
    #1;
    check("rst_mid_clear_busy", DW'(bus.Clear_Busy), 32'h0);
    check("rst_mid_data_20", bus.R_Data_A, 32'h0);
    check("rst_mid_busy_15", DW'(bus.R_Busy_B), 32'h0);
    bus.R_Addr_A = 5'd25;
    #1;
    check("rst_mid_data_25", bus.R_Data_A, 32'h0);
    model_reset();
    #2;
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Random traffic against the model, including level-held clear requests
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, DEPTH - 1));
      apply_stimulus($urandom_range(0, 1) == 1, wa, $urandom,
                     $urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)),
                     $urandom_range(0, 79) == 0 || (bus.Clear_Req && $urandom_range(0, 1) == 1),
                     ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)),
                     AW'($urandom_range(0, DEPTH - 1)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
